// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, ALU operation codes, writeback sources
// and the decoded control bundle passed from decode_logic to the stage registers.
package decode_pkg;

    localparam logic [6:0] OpcLoad    = 7'b0000011;
    localparam logic [6:0] OpcMiscMem = 7'b0001111;
    localparam logic [6:0] OpcOpImm   = 7'b0010011;
    localparam logic [6:0] OpcAuipc   = 7'b0010111;
    localparam logic [6:0] OpcOpImm32 = 7'b0011011;
    localparam logic [6:0] OpcStore   = 7'b0100011;
    localparam logic [6:0] OpcOp      = 7'b0110011;
    localparam logic [6:0] OpcLui     = 7'b0110111;
    localparam logic [6:0] OpcOp32    = 7'b0111011;
    localparam logic [6:0] OpcBranch  = 7'b1100011;
    localparam logic [6:0] OpcJalr    = 7'b1100111;
    localparam logic [6:0] OpcJal     = 7'b1101111;
    localparam logic [6:0] OpcSystem  = 7'b1110011;

    localparam logic [31:0] InstrEcall  = 32'h0000_0073;
    localparam logic [31:0] InstrEbreak = 32'h0010_0073;
    localparam logic [6:0]  Funct7Mext  = 7'b0000001;

    // AluNone (0) is reported for opcodes that need no ALU and for illegal words.
    typedef enum logic [4:0] {
        AluNone, AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd,
        AluMul, AluMulh, AluMulhsu, AluMulhu, AluDiv, AluDivu, AluRem, AluRemu,
        AluAddw, AluSubw, AluSllw, AluSrlw, AluSraw,
        AluMulw, AluDivw, AluDivuw, AluRemw, AluRemuw
    } alu_op_e;

    typedef enum logic [1:0] {
        SrcAlu = 2'b00,
        SrcMem = 2'b01,
        SrcPc4 = 2'b10,
        SrcImm = 2'b11
    } reg_src_e;

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} buf_state_e;

    typedef struct packed {
        alu_op_e    alu_op;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       reg_wen;
        logic       mem_wen;
        logic       mem_ren;
        logic       jump;
        logic       branch;
        logic       auipc;
        logic       jalr;
        reg_src_e   reg_src;
        logic [2:0] funct3;
        logic       ebreak;
        logic       ecall;
        logic       illegal;
    } dec_ctrl_t;

    function automatic alu_op_e base_alu_op(input logic [2:0] funct3, input logic sub,
                                            input logic sra);
        case (funct3)
            3'b000:  return sub ? AluSub : AluAdd;
            3'b001:  return AluSll;
            3'b010:  return AluSlt;
            3'b011:  return AluSltu;
            3'b100:  return AluXor;
            3'b101:  return sra ? AluSra : AluSrl;
            3'b110:  return AluOr;
            default: return AluAnd;
        endcase
    endfunction

endpackage

// File: rtl/decode_logic.sv
// Combinational RV32/RV64 (+M) instruction decoder: raw word in, control bundle
// and sign-extended immediate out.
module decode_logic import decode_pkg::*; #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned M_EXT = 0
) (
    input  logic [31:0]     instr,
    output dec_ctrl_t       ctrl,
    output logic [XLEN-1:0] imme
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        alt;
    logic        is_m;
    logic        illegal;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign alt    = instr[30];
    assign is_m   = (instr[31:25] == Funct7Mext);

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        ctrl        = '0;
        imm32       = '0;
        illegal     = 1'b0;
        ctrl.rs1    = instr[19:15];
        ctrl.rs2    = instr[24:20];
        ctrl.rd     = instr[11:7];
        ctrl.funct3 = funct3;
        ctrl.ebreak = (instr == InstrEbreak);
        ctrl.ecall  = (instr == InstrEcall);

        case (opcode)
            OpcLui: begin
                ctrl.reg_wen = 1'b1;
                ctrl.reg_src = SrcImm;
                imm32        = imm_u;
            end
            OpcAuipc: begin
                ctrl.reg_wen = 1'b1;
                ctrl.auipc   = 1'b1;
                ctrl.alu_op  = AluAdd;
                imm32        = imm_u;
            end
            OpcJal: begin
                ctrl.reg_wen = 1'b1;
                ctrl.jump    = 1'b1;
                ctrl.reg_src = SrcPc4;
                imm32        = imm_j;
            end
            OpcJalr: begin
                ctrl.reg_wen = 1'b1;
                ctrl.jump    = 1'b1;
                ctrl.jalr    = 1'b1;
                ctrl.reg_src = SrcPc4;
                imm32        = imm_i;
            end
            OpcBranch: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = funct3[1] ? AluSltu : AluSlt;
                imm32       = imm_b;
            end
            OpcLoad: begin
                ctrl.reg_wen = 1'b1;
                ctrl.mem_ren = 1'b1;
                ctrl.reg_src = SrcMem;
                ctrl.alu_op  = AluAdd;
                imm32        = imm_i;
            end
            OpcStore: begin
                ctrl.mem_wen = 1'b1;
                ctrl.alu_op  = AluAdd;
                imm32        = imm_s;
            end
            OpcOpImm: begin
                ctrl.reg_wen = 1'b1;
                ctrl.alu_op  = base_alu_op(funct3, 1'b0, alt);
                imm32        = imm_i;
            end
            OpcOp: begin
                ctrl.reg_wen = 1'b1;
                if (!is_m) begin
                    ctrl.alu_op = base_alu_op(funct3, alt, alt);
                end else if (M_EXT != 0) begin
                    ctrl.alu_op = alu_op_e'(5'(AluMul) + 5'(funct3));
                end else begin
                    illegal = 1'b1;
                end
            end
            OpcOpImm32, OpcOp32: begin
                ctrl.reg_wen = 1'b1;
                if (opcode == OpcOpImm32) imm32 = imm_i;
                if (XLEN == 32) begin
                    illegal = 1'b1;
                end else if (opcode == OpcOp32 && is_m) begin
                    // MULW/DIVW/DIVUW/REMW/REMUW only; funct3 1..3 have no W form.
                    if (M_EXT == 0) illegal = 1'b1;
                    case (funct3)
                        3'b000:  ctrl.alu_op = AluMulw;
                        3'b100:  ctrl.alu_op = AluDivw;
                        3'b101:  ctrl.alu_op = AluDivuw;
                        3'b110:  ctrl.alu_op = AluRemw;
                        3'b111:  ctrl.alu_op = AluRemuw;
                        default: illegal = 1'b1;
                    endcase
                end else begin
                    case (funct3)
                        3'b000:  ctrl.alu_op = (opcode == OpcOp32 && alt) ? AluSubw : AluAddw;
                        3'b001:  ctrl.alu_op = AluSllw;
                        3'b101:  ctrl.alu_op = alt ? AluSraw : AluSrlw;
                        default: illegal = 1'b1;
                    endcase
                end
            end
            OpcMiscMem: ;
            OpcSystem: imm32 = imm_i;
            default:   illegal = 1'b1;
        endcase

        if (instr[1:0] != 2'b11) illegal = 1'b1;

        if (illegal) begin
            ctrl.alu_op  = AluNone;
            ctrl.reg_wen = 1'b0;
            ctrl.mem_wen = 1'b0;
            ctrl.mem_ren = 1'b0;
            ctrl.jump    = 1'b0;
            ctrl.branch  = 1'b0;
        end
        ctrl.illegal = illegal;
        imme         = XLEN'($signed(imm32));
    end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: decoder followed by a two-entry skid buffer so that
// in_ready depends only on registered state.
module decode_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned M_EXT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_alu_op,
    output logic [XLEN-1:0] out_imme,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_reg_wen,
    output logic            out_mem_wen,
    output logic            out_mem_ren,
    output logic            out_jump,
    output logic            out_branch,
    output logic            out_auipc,
    output logic            out_jalr,
    output logic [1:0]      out_reg_src,
    output logic [2:0]      out_funct3,
    output logic            out_ebreak,
    output logic            out_ecall,
    output logic            out_illegal
);
    import decode_pkg::*;

    buf_state_e      state_q, state_d;
    dec_ctrl_t       dec_ctrl, out_ctrl_q, skid_ctrl_q;
    logic [XLEN-1:0] dec_imme, out_imme_q, skid_imme_q, out_pc_q, skid_pc_q;
    logic            xfer_in, xfer_out, load_out, load_skid, out_from_skid;

    decode_logic #(
        .XLEN  (XLEN),
        .M_EXT (M_EXT)
    ) u_decode_logic (
        .instr (in_instr),
        .ctrl  (dec_ctrl),
        .imme  (dec_imme)
    );

    assign in_ready  = (state_q != StTwo);
    assign out_valid = (state_q != StEmpty);
    assign xfer_in   = in_valid & in_ready;
    assign xfer_out  = out_valid & out_ready;

    always_comb begin
        state_d       = state_q;
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        case (state_q)
            StEmpty: begin
                if (xfer_in) begin
                    state_d  = StOne;
                    load_out = 1'b1;
                end
            end
            StOne: begin
                case ({xfer_in, xfer_out})
                    2'b10: begin
                        state_d   = StTwo;
                        load_skid = 1'b1;
                    end
                    2'b01:   state_d  = StEmpty;
                    2'b11:   load_out = 1'b1;
                    default: ;
                endcase
            end
            StTwo: begin
                if (xfer_out) begin
                    state_d       = StOne;
                    out_from_skid = 1'b1;
                end
            end
            default: state_d = StEmpty;
        endcase
        // Flush wins over any transfer; the word offered this cycle is dropped.
        if (flush) begin
            state_d       = StEmpty;
            load_out      = 1'b0;
            load_skid     = 1'b0;
            out_from_skid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StEmpty;
            out_ctrl_q  <= '0;
            out_imme_q  <= '0;
            out_pc_q    <= '0;
            skid_ctrl_q <= '0;
            skid_imme_q <= '0;
            skid_pc_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load_out) begin
                out_ctrl_q <= dec_ctrl;
                out_imme_q <= dec_imme;
                out_pc_q   <= in_pc;
            end else if (out_from_skid) begin
                out_ctrl_q <= skid_ctrl_q;
                out_imme_q <= skid_imme_q;
                out_pc_q   <= skid_pc_q;
            end
            if (load_skid) begin
                skid_ctrl_q <= dec_ctrl;
                skid_imme_q <= dec_imme;
                skid_pc_q   <= in_pc;
            end
        end
    end

    assign out_pc      = out_pc_q;
    assign out_imme    = out_imme_q;
    assign out_alu_op  = out_ctrl_q.alu_op;
    assign out_rs1     = out_ctrl_q.rs1;
    assign out_rs2     = out_ctrl_q.rs2;
    assign out_rd      = out_ctrl_q.rd;
    assign out_reg_wen = out_ctrl_q.reg_wen;
    assign out_mem_wen = out_ctrl_q.mem_wen;
    assign out_mem_ren = out_ctrl_q.mem_ren;
    assign out_jump    = out_ctrl_q.jump;
    assign out_branch  = out_ctrl_q.branch;
    assign out_auipc   = out_ctrl_q.auipc;
    assign out_jalr    = out_ctrl_q.jalr;
    assign out_reg_src = out_ctrl_q.reg_src;
    assign out_funct3  = out_ctrl_q.funct3;
    assign out_ebreak  = out_ctrl_q.ebreak;
    assign out_ecall   = out_ctrl_q.ecall;
    assign out_illegal = out_ctrl_q.illegal;

endmodule
